// File: rtl/sh_bus_slave.sv
// SH7604 CS0-area bus responder: wait-state insertion, backing-memory handshake, COMM register file.
// Optional COMM register file and host port: define SH_BUS_SLAVE_COMM_EN.
module sh_bus_slave #(
   parameter int WAIT_STATES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CE_R,
   input  logic         CE_F,
   input  logic [26:0]  A,
   input  logic [31:0]  DI,
   output logic [31:0]  DO,
   input  logic         CS0_N,
   input  logic         RD_N,
   input  logic [3:0]   WE_N,
   output logic         WAIT_N,
   output logic [26:0]  MEM_A,
   output logic [31:0]  MEM_D,
   output logic [3:0]   MEM_WE,
   output logic         MEM_REQ,
   input  logic [31:0]  MEM_Q,
   input  logic         MEM_RDY,
   input  logic         HOST_WR,
   input  logic [2:0]   HOST_IDX,
   input  logic [15:0]  HOST_D,
   output logic [127:0] COMM_Q,
   output logic         ERR
);

   // state      | meaning
   // S_IDLE     | waiting for a CS0 strobe
   // S_WAIT     | counting programmed wait states, WAIT_N low
   // S_MEM_WAIT | MEM_REQ high, waiting for MEM_RDY or timeout
   // S_DONE     | WAIT_N high, DO held until strobes release
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEM_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {R_MEM, R_REG, R_NULL} region_t;

   localparam logic [3:0] WS      = 4'(WAIT_STATES);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   region_t     region;
   logic [3:0]  wcnt;
   logic [7:0]  tcnt;
   logic        is_rd;
   logic        strobe_on;
   logic        direct;
   logic [12:0] sel_blk;
   logic [31:0] rd_data;

   function automatic region_t decode(input logic [12:0] blk);
      if (blk == 13'd0)
         return R_MEM;
`ifdef SH_BUS_SLAVE_COMM_EN
      else if (blk == 13'd1)
         return R_REG;
`endif
      else
         return R_NULL;
   endfunction

   assign strobe_on = !CS0_N && (!RD_N || (WE_N != 4'hF));
   assign sel_blk   = (state == S_IDLE) ? A[26:14] : MEM_A[26:14];
   assign region    = decode(sel_blk);
   assign direct    = (WS == 4'd0) && (region != R_MEM);

`ifdef SH_BUS_SLAVE_COMM_EN
   logic [15:0] comm [8];
   logic [4:0]  sel_off;
   logic [31:0] sel_d;
   logic [3:0]  sel_we;
   logic        sel_rd;
   logic        finish;
   logic        cpu_wr;
   logic [1:0]  wr_be;
   logic [15:0] wr_data;
   logic        unused_ok;

   assign unused_ok = CE_F;

   // The direct (zero-wait) path decodes the live bus; otherwise the latched access.
   always_comb begin
      sel_off = (state == S_IDLE) ? A[5:1] : MEM_A[5:1];
      sel_d   = (state == S_IDLE) ? DI : MEM_D;
      sel_we  = (state == S_IDLE) ? ~WE_N : MEM_WE;
      sel_rd  = (state == S_IDLE) ? !RD_N : is_rd;
      rd_data = '0;
      if (region == R_REG) begin
         if (sel_off == 5'd0)
            rd_data = {2{16'h0200}};
         else if (sel_off[4:3] == 2'b10)
            rd_data = {2{comm[sel_off[2:0]]}};
      end
      finish  = CE_R && (((state == S_IDLE) && strobe_on && direct) ||
                         ((state == S_WAIT) && strobe_on && (wcnt == 4'd0) && (region != R_MEM)));
      cpu_wr  = finish && !sel_rd && (region == R_REG) && (sel_off[4:3] == 2'b10);
      wr_be   = sel_off[0] ? sel_we[1:0] : sel_we[3:2];
      wr_data = sel_off[0] ? sel_d[15:0] : sel_d[31:16];
   end

   // Host write is applied last so it wins a same-edge collision.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 8; i++) comm[i] <= '0;
      end else if (CE_R) begin
         if (cpu_wr) begin
            if (wr_be[1]) comm[sel_off[2:0]][15:8] <= wr_data[15:8];
            if (wr_be[0]) comm[sel_off[2:0]][7:0]  <= wr_data[7:0];
         end
         if (HOST_WR) comm[HOST_IDX] <= HOST_D;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) COMM_Q[i*16 +: 16] = comm[i];
   end
`else
   logic unused_ok;

   assign unused_ok = ^{CE_F, HOST_WR, HOST_IDX, HOST_D};
   assign rd_data   = '0;
   assign COMM_Q    = '0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         WAIT_N  <= 1'b1;
         DO      <= '0;
         MEM_REQ <= 1'b0;
         MEM_WE  <= '0;
         MEM_A   <= '0;
         MEM_D   <= '0;
         ERR     <= 1'b0;
         wcnt    <= '0;
         tcnt    <= '0;
         is_rd   <= 1'b0;
      end else if (CE_R) begin
         ERR <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (strobe_on) begin
                  MEM_A  <= A;
                  MEM_D  <= DI;
                  MEM_WE <= ~WE_N;
                  is_rd  <= !RD_N;
                  WAIT_N <= 1'b0;
                  wcnt   <= WS;
                  if (direct) begin
                     state <= S_DONE;
                     if (!RD_N) DO <= rd_data;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!strobe_on) begin
                  state  <= S_IDLE;
                  WAIT_N <= 1'b1;
               end else if (wcnt == 4'd0) begin
                  if (region == R_MEM) begin
                     state   <= S_MEM_WAIT;
                     MEM_REQ <= 1'b1;
                     tcnt    <= '0;
                  end else begin
                     state  <= S_DONE;
                     WAIT_N <= 1'b1;
                     if (is_rd) DO <= rd_data;
                  end
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            S_MEM_WAIT: begin
               if (!strobe_on) begin
                  state   <= S_IDLE;
                  MEM_REQ <= 1'b0;
                  WAIT_N  <= 1'b1;
               end else if (MEM_RDY && MEM_REQ) begin
                  if (is_rd) DO <= MEM_Q;
                  MEM_REQ <= 1'b0;
                  WAIT_N  <= 1'b1;
                  state   <= S_DONE;
               end else if (tcnt == TO_LAST) begin
                  DO      <= 32'hFFFF_FFFF;
                  ERR     <= 1'b1;
                  MEM_REQ <= 1'b0;
                  WAIT_N  <= 1'b1;
                  state   <= S_DONE;
               end else if (tcnt != 8'hFF) begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            S_DONE: begin
               WAIT_N <= 1'b1;
               if (!strobe_on) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
